gf2m_alu_param: RTL
===================

Name: gf2m_alu_param

Overview:
Parametrised GF(2^M) arithmetic unit for the ECC datapath. It supports field addition, full modular multiplication and repeated squaring (a squaring chain for inversion and point-arithmetic sequences). Multiplication uses a D-bit digit-serial MSB-first multiplier with interleaved reduction by the field polynomial, so every result is reduced to M bits. It sits between the point-operation controller and the register file and uses a start/busy/done handshake.

Parameters:
M, 163, field degree and operand/result width
D, 4, multiplier digit size in bits; 1 <= D < M
POLY, 163'hC9, low M bits of the reduction polynomial f(x) = x^M + POLY (default x^163+x^7+x^6+x^3+1)
KW, 8, width of the squaring-count input

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  operation request; sampled only in IDLE
op  in  2  00 add, 01 multiply, 10 square, 11 square-chain
a  in  M  operand A; captured on accepted start
b  in  M  operand B; captured on accepted start, ignored for op 10/11
k  in  KW  squaring count for op 11; captured on accepted start
busy  out  1  high from the cycle after an accepted start through the done cycle
done  out  1  one-cycle pulse; result valid in that cycle
result  out  M  last completed result; held until the next done

Behaviour:
- Reset (rst low, async) forces: state IDLE, busy=0, done=0, result=0, internal accumulator/counters=0. Reset mid-operation aborts with no done pulse.
- N = ceil(M/D) digit cycles. b is zero-extended to N*D bits and consumed MSB digit first.
- States:
  - IDLE: start=1 captures a, b, op, k and sets busy. op 00 -> ADD; op 01/10 -> MUL; op 11 -> MUL if k>0, else ADD-path pass-through of a.
  - ADD: result <= a^b (op 00) or a (op 11, k=0). done pulse. Return to IDLE.
  - MUL: per cycle acc <= reduce(acc*x^D) ^ (a_op * digit), where a_op*digit is reduced mod f. N cycles. acc is cleared on entry.
  - FIN: result <= acc. done pulse. For op 11 with remaining count >0: a_op <= acc, b_op <= acc, decrement count, re-enter MUL with no done pulse; otherwise return to IDLE.
  - Op 10 is op 01 with b_op = a.
- Latency, with start accepted at edge t:
  - add: done at t+1
  - mul/square: done at t+N+1 (163/4: t+42)
  - square-chain: done at t+k*(N+1)
- busy falls in the cycle after done. A new start is accepted in the cycle after done and not earlier.
- start while busy is ignored: no capture, no effect on the running operation.
- Inputs a, b, k, op may change freely after the start cycle.
- done and start in the same cycle: start is not accepted (busy still 1).
- Reduction identity: x^M = POLY. All intermediate values are kept below M bits after each cycle.

Test Plan:
- Reset: hold rst=0 with random inputs -> busy=0, done=0, result=0. Release -> still idle, no done.
- Add: a=163'h5, b=163'h3, op=00 -> done 1 cycle after start, result=163'h6. Then start op 11 with k=0, a=163'h7 -> result=163'h7 at t+1.
- Multiply: a=1, b=random R -> result=R at t+42. a=x^162 (bit162), b=2 -> result=163'hC9 (reduction). a=b=x^100 -> result = x^37*(x^7+x^6+x^3+1) = bits 44,43,40,37 set.
- Square-chain: a=163'h2 (x), k=3, op=11 -> exactly one done at t+126, result=163'h100. Same with k=1 and op 10 -> result=163'h4 at t+42.
- Handshake: issue start every cycle during a multiply -> only the first is accepted, one done at t+42, next start accepted at t+43. Compare against the reference model over 1000 random a,b with D in {1,4,8}.
- Mid-operation reset: assert rst at t+20 of a multiply -> outputs zero immediately, no done. A fresh multiply after release gives the correct result.

Source files
------------

// File: rtl/gf2m_alu_param_if.sv
// Start/busy/done request bundle for the GF(2^M) arithmetic unit.
// The controller drives the master side; the ALU implements the slave side.
interface gf2m_alu_param_if #(
  parameter int M  = 163,
  parameter int KW = 8
);
  logic          start;
  logic [1:0]    op;
  logic [M-1:0]  a;
  logic [M-1:0]  b;
  logic [KW-1:0] k;
  logic          busy;
  logic          done;
  logic [M-1:0]  result;

  modport master (
    output start, op, a, b, k,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b, k,
    output busy, done, result
  );
endinterface

// File: rtl/gf2m_alu_param.sv
// GF(2^M) add / digit-serial multiply / square-chain unit.
// Multiplier is D-bit MSB-first with interleaved reduction by x^M + POLY.
module gf2m_alu_param #(
  parameter int          M    = 163,
  parameter int          D    = 4,
  parameter logic [M-1:0] POLY = 'hC9,
  parameter int          KW   = 8
) (
  input logic             clk,
  input logic             rst,
  gf2m_alu_param_if.slave bus
);

  localparam int N  = (M + D - 1) / D;
  localparam int W  = N * D;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_MUL,
    S_FIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [M-1:0]  a_q, a_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [M-1:0]  acc_q, acc_d;
  logic [M-1:0]  res_q, res_d;
  logic [1:0]    op_q, op_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  step;

  // Horner over one digit: acc*x^D + a*digit, reduced every bit.
  always_comb begin
    step = acc_q;
    for (int i = D - 1; i >= 0; i--) begin
      step = {step[M-2:0], 1'b0}
           ^ ({M{step[M-1]}} & POLY)
           ^ ({M{sh_q[W-D+i]}} & a_q);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    res_d   = res_q;
    op_d    = op_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.a;
          op_d  = bus.op;
          k_d   = bus.k;
          acc_d = '0;
          cnt_d = '0;
          sh_d  = W'(bus.op[1] ? bus.a : bus.b);
          if (bus.op == 2'b00 ||
              (bus.op == 2'b11 && bus.k == '0))
            state_d = S_ADD;
          else
            state_d = S_MUL;
        end
      end
      S_ADD: begin
        res_d   = (op_q == 2'b00) ? (a_q ^ sh_q[M-1:0]) : a_q;
        state_d = S_DONE;
      end
      S_MUL: begin
        acc_d = step;
        sh_d  = sh_q << D;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1))
          state_d = S_FIN;
      end
      S_FIN: begin
        // Chain: feed the square back in as both operands.
        if (op_q == 2'b11 && k_q > KW'(1)) begin
          a_d     = acc_q;
          sh_d    = W'(acc_q);
          k_d     = k_q - 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end else begin
          res_d   = acc_q;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      op_q    <= op_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = res_q;

endmodule
